// File: rtl/present_pkg.sv
// Shared PRESENT key-schedule definitions: sbox tables, round/rotation
// constants and the decryption key-schedule state encoding.
package present_pkg;

  localparam int unsigned KEY_W  = 80;
  localparam int unsigned RK_W   = 64;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned ROUNDS = 31;
  localparam int unsigned ROT    = 61;

  // Nibble x of each table lives at bits [4*x+3:4*x]
  localparam logic [63:0] SBOX_TBL     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] SBOX_INV_TBL = 64'hA970364BD21C8FE5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_SERVE  = 2'd2
  } state_t;

endpackage

// File: rtl/sbox.sv
// PRESENT forward 4-bit sbox, pure lookup.
module sbox
  import present_pkg::*;
(
  input  logic [3:0] x,
  output logic [3:0] y_c
);

  assign y_c = SBOX_TBL[{x, 2'b00} +: 4];

endmodule

// File: rtl/sbox_inv.sv
// PRESENT inverse 4-bit sbox, pure lookup.
module sbox_inv
  import present_pkg::*;
(
  input  logic [3:0] x,
  output logic [3:0] y_c
);

  assign y_c = SBOX_INV_TBL[{x, 2'b00} +: 4];

endmodule

// File: rtl/present_dec_key_sched.sv
// PRESENT-80 decryption key scheduler: expands the master key forward to the
// round-32 state, then serves round keys 32..1 by stepping the schedule back.
// Optional PRESENT_DEC_DIRECT_LOAD_EN adds last_i to load a round-32 state directly.
module present_dec_key_sched
  import present_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
`ifdef PRESENT_DEC_DIRECT_LOAD_EN
  input  logic             last_i,
`endif
  input  logic [KEY_W-1:0] key_i,
  input  logic             next_i,
  output logic [RK_W-1:0]  round_key_o,
  output logic [CNT_W-1:0] round_o,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o
);

  state_t             state, state_d;
  logic [KEY_W-1:0]   kreg, kreg_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [CNT_W-1:0]   round, round_d;
  logic               ready_d, busy_d, done_d;
  logic               direct_load;

  logic [KEY_W-1:0]   rot_l;
  logic [KEY_W-1:0]   fwd_key;
  logic [KEY_W-1:0]   inv_pre;
  logic [KEY_W-1:0]   inv_key;
  logic [CNT_W-1:0]   round_m1;
  logic [3:0]         sbox_y;
  logic [3:0]         sbox_inv_y;

`ifdef PRESENT_DEC_DIRECT_LOAD_EN
  assign direct_load = last_i;
`else
  assign direct_load = 1'b0;
`endif

  // Round 32 is held as 0, so step down from it explicitly instead of wrapping
  assign round_m1 = (round == '0) ? CNT_W'(ROUNDS) : round - CNT_W'(1);

  // Forward step: rotl 61, sbox top nibble, mix in the counter
  assign rot_l = {kreg[KEY_W-ROT-1:0], kreg[KEY_W-1:KEY_W-ROT]};

  sbox u_sbox (
    .x   (rot_l[KEY_W-1 -: 4]),
    .y_c (sbox_y)
  );

  always_comb begin
    fwd_key              = rot_l;
    fwd_key[KEY_W-1 -: 4] = sbox_y;
    fwd_key[19:15]       = rot_l[19:15] ^ cnt;
  end

  // Inverse step: unmix counter, inverse sbox top nibble (untouched by the XOR), rotr 61
  sbox_inv u_sbox_inv (
    .x   (kreg[KEY_W-1 -: 4]),
    .y_c (sbox_inv_y)
  );

  always_comb begin
    inv_pre               = kreg;
    inv_pre[19:15]        = kreg[19:15] ^ round_m1;
    inv_pre[KEY_W-1 -: 4] = sbox_inv_y;
    inv_key               = {inv_pre[ROT-1:0], inv_pre[KEY_W-1:ROT]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      kreg    <= '0;
      cnt     <= '0;
      round   <= '0;
      ready_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state   <= state_d;
      kreg    <= kreg_d;
      cnt     <= cnt_d;
      round   <= round_d;
      ready_o <= ready_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    kreg_d  = kreg;
    cnt_d   = cnt;
    round_d = round;
    done_d  = 1'b0;

    if (load_i) begin
      kreg_d = key_i;
      if (direct_load) begin
        cnt_d   = CNT_W'(ROUNDS);
        round_d = '0;
        state_d = ST_SERVE;
      end else begin
        cnt_d   = CNT_W'(1);
        state_d = ST_EXPAND;
      end
    end else begin
      unique case (state)
        ST_EXPAND: begin
          kreg_d = fwd_key;
          if (cnt == CNT_W'(ROUNDS)) begin
            round_d = '0;
            state_d = ST_SERVE;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        ST_SERVE: begin
          if (next_i) begin
            if (round == CNT_W'(1)) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              kreg_d  = inv_key;
              cnt_d   = round_m1;
              round_d = round_m1;
            end
          end
        end
        default: ;
      endcase
    end

    ready_d = (state_d == ST_SERVE);
    busy_d  = (state_d == ST_EXPAND);
  end

  assign round_key_o = kreg[KEY_W-1:KEY_W-RK_W];
  assign round_o     = round;

endmodule

// File: tb/tb_present_dec_key_sched.sv
// Scoreboard bench for present_dec_key_sched: a forward-schedule model feeds
// expected keys 32..1 into a queue that a negedge monitor drains.
module tb_present_dec_key_sched;

  typedef struct {
    bit          is_done;
    logic [4:0]  round;
    logic [63:0] key;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_i;
  logic        last_i;
  logic [79:0] key_i;
  logic        next_i;
  logic [63:0] round_key_o;
  logic [4:0]  round_o;
  logic        ready_o, busy_o, done_o;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  logic [79:0] model_k [1:32];
  logic [3:0]  sref [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  present_dec_key_sched dut (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_i),
`ifdef PRESENT_DEC_DIRECT_LOAD_EN
    .last_i      (last_i),
`endif
    .key_i       (key_i),
    .next_i      (next_i),
    .round_key_o (round_key_o),
    .round_o     (round_o),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Forward key schedule: state i holds the key register for round i
  task automatic build_model(input logic [79:0] k);
    logic [79:0] s;
    s = k;
    model_k[1] = s;
    for (int i = 1; i <= 31; i++) begin
      s = (s << 61) | (s >> 19);
      s[79:76] = sref[s[79:76]];
      s[19:15] = s[19:15] ^ 5'(i);
      model_k[i + 1] = s;
    end
  endtask

  task automatic push_key(input int r);
    exp_t e;
    e.is_done = 1'b0;
    e.round   = 5'(r);
    e.key     = model_k[r][79:16];
    sb.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.round   = '0;
    e.key     = '0;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a new key is presented when ready rises or after a step/load while ready
  bit ready_q = 1'b0, step_q = 1'b0, load_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ready_o && (!ready_q || step_q || load_q)) begin
        if (sb.size() == 0) begin
          check("unexpected_key", 80'(round_o), 80'h1_0000);
        end else begin
          e = sb.pop_front();
          check("key_kind", 80'(0), 80'(e.is_done));
          check("round", 80'(round_o), 80'(e.round));
          check("round_key", 80'(round_key_o), 80'(e.key));
        end
      end
      if (done_o) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 80'(done_o), 80'(0));
        end else begin
          e = sb.pop_front();
          check("done_kind", 80'(1), 80'(e.is_done));
        end
      end
    end
    ready_q = ready_o;
    step_q  = next_i && ready_o;
    load_q  = load_i;
  end

  task automatic wait_ready(input bit next_in_expand);
    int n;
    n = 0;
    if (next_in_expand) next_i = 1'b1;
    while (!ready_o && n < 40) begin
      cyc();
      n++;
    end
    next_i = 1'b0;
    check("ready_latency", 80'(n), 80'(31));
  endtask

  task automatic step(input int r);
    push_key(r);
    next_i = 1'b1;
    cyc();
    next_i = 1'b0;
  endtask

  // Load k through EXPAND and serve keys down to stop_at (1 = full run with done)
  task automatic run(input logic [79:0] k, input int stop_at, input bit next_in_expand);
    build_model(k);
    push_key(32);
    key_i  = k;
    load_i = 1'b1;
    cyc();
    load_i = 1'b0;
    check("busy_after_load", 80'(busy_o), 80'(1));
    wait_ready(next_in_expand);
    for (int r = 31; r >= stop_at; r--) begin
      step(r);
      if (r == 2 && k == 80'h0) check("zero_key_round2", 80'(round_key_o), 80'h0_C000_0000_0000_0000);
    end
    if (stop_at == 1) begin
      check("round1_is_master", 80'(round_key_o), 80'(k[79:16]));
      push_done();
      next_i = 1'b1;
      cyc();
      next_i = 1'b0;
      check("ready_after_done", 80'(ready_o), 80'(0));
      cyc();
      check("done_one_cycle", 80'(done_o), 80'(0));
    end
  endtask

  function automatic logic [79:0] rand_key();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[79:0];
  endfunction

  initial begin
    rst = 1'b1; load_i = 1'b0; last_i = 1'b0; key_i = '0; next_i = 1'b0;
    cyc(); cyc();
    check("rst_key", 80'(round_key_o), 80'(0));
    check("rst_round", 80'(round_o), 80'(0));
    check("rst_flags", 80'({ready_o, busy_o, done_o}), 80'(0));
    rst = 1'b0;
    cyc();

    run(80'h0, 1, 1'b0);
    run(80'hFFFF_FFFF_FFFF_FFFF_FFFF, 1, 1'b0);

    // Reload mid-SERVE at round 17, then ignore next_i throughout EXPAND
    run(rand_key(), 17, 1'b0);
    check("round_before_reload", 80'(round_o), 80'(17));
    run(rand_key(), 1, 1'b1);

    for (int i = 0; i < 100; i++) run(rand_key(), 1, 1'b0);

    // Reset 10 cycles into EXPAND abandons everything
    key_i  = rand_key();
    load_i = 1'b1;
    cyc();
    load_i = 1'b0;
    repeat (10) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_key", 80'(round_key_o), 80'(0));
    check("midrst_round", 80'(round_o), 80'(0));
    check("midrst_flags", 80'({ready_o, busy_o, done_o}), 80'(0));
    repeat (40) cyc();
    check("midrst_stays_idle", 80'({ready_o, busy_o}), 80'(0));

`ifdef PRESENT_DEC_DIRECT_LOAD_EN
    for (int i = 0; i < 4; i++) begin
      logic [79:0] k;
      k = rand_key();
      build_model(k);
      push_key(32);
      key_i  = model_k[32];
      load_i = 1'b1;
      last_i = 1'b1;
      cyc();
      load_i = 1'b0;
      last_i = 1'b0;
      check("direct_ready", 80'(ready_o), 80'(1));
      for (int r = 31; r >= 1; r--) step(r);
      check("direct_round1", 80'(round_key_o), 80'(k[79:16]));
      push_done();
      next_i = 1'b1;
      cyc();
      next_i = 1'b0;
      cyc();
    end
`endif

    repeat (3) cyc();
    check("scoreboard_drained", 80'(sb.size()), 80'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
